// File: rtl/div_unit.sv
// Iterative 32-bit RV32 divider (DIV/DIVU/REM/REMU), restoring radix-2, fixed 33-cycle latency.
// Result and flags are registered in FIX and held until the next operation completes.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      opt,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out,
    output logic            div_zero_flag,
    output logic            overflow_flag
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic            zero_q, zero_d, ovf_q, ovf_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d, div_q, div_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            done_q, done_d, dz_q, dz_d, of_q, of_d;

    logic            is_signed;
    logic [XLEN-1:0] abs_a, abs_b, quo_res, rem_res;
    logic [XLEN:0]   shifted, trial;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            out_q    <= out_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            of_q     <= of_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        out_d    = out_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        of_d     = of_q;

        is_signed = ~opt[0];
        abs_a     = (is_signed && in_a[XLEN-1]) ? -in_a : in_a;
        abs_b     = (is_signed && in_b[XLEN-1]) ? -in_b : in_b;

        // 33-bit trial: rem < divisor keeps the true difference inside 33 bits, so bit 32 is the sign
        shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        trial   = shifted - {1'b0, div_q};

        // sign bits are only latched for signed ops; with a zero divisor the
        // corrected remainder reproduces the raw dividend
        quo_res = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        rem_res = sign_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = opt;
                    sign_a_d = is_signed & in_a[XLEN-1];
                    sign_b_d = is_signed & in_b[XLEN-1];
                    zero_d   = (in_b == '0);
                    ovf_d    = is_signed && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
                    quo_d    = abs_a;
                    div_d    = abs_b;
                    rem_d    = '0;
                    cnt_d    = CW'(XLEN - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (!trial[XLEN]) rem_d = trial;
                else              rem_d = shifted;
                quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d = cnt_q - 1'b1;
            end
            FIX: begin
                if (op_q[1]) out_d = rem_res;
                else         out_d = zero_q ? '1 : quo_res;
                dz_d    = zero_q;
                of_d    = ovf_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign out           = out_q;
    assign div_zero_flag = dz_q;
    assign overflow_flag = of_q;

endmodule
